// File: rtl/stage_router.sv
// stage_router: forwards the outputs of the stage selected by cur_stage to the
// matrix driver, buzzer and stage controller. Switches are synchronised and
// debounced into levels plus one-cycle rise pulses. Every stage change opens a
// blanking window that darkens LEDs and sound and suppresses switch pulses and
// stage requests, so a press cannot leak into the stage that follows it.
module stage_router #(
    parameter int NUM_STAGES   = 5,
    parameter int STAGE_W      = 3,
    parameter int NUM_SW       = 4,
    parameter int NOTE_W       = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int BLANK_CYC    = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SW-1:0]              sw_value,
    input  logic [STAGE_W-1:0]             cur_stage,
    input  logic [6*NUM_STAGES-1:0]        st_rgb,
    input  logic [NUM_STAGES-1:0]          st_sound_en,
    input  logic [NOTE_W*NUM_STAGES-1:0]   st_note_sel,
    input  logic [STAGE_W*NUM_STAGES-1:0]  st_next_flag,
    input  logic [2*NUM_STAGES-1:0]        st_stage_sel,
    output logic [NUM_SW-1:0]              sw_level,
    output logic [NUM_SW-1:0]              sw_raise,
    output logic [5:0]                     rgb_out,
    output logic                           sound_en,
    output logic [NOTE_W-1:0]              note_sel,
    output logic [STAGE_W-1:0]             next_stage_flag,
    output logic [1:0]                     stage_select,
    output logic                           blanking
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BL_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BL_LOAD = BL_W'(BLANK_CYC - 1);

    // ST_BLANK is exactly the blanking output, so the state is visible at the port.
    typedef enum logic {ST_RUN = 1'b0, ST_BLANK = 1'b1} state_t;

    logic [NUM_SW-1:0]            sync1_q, sync1_d;
    logic [NUM_SW-1:0]            sync2_q, sync2_d;
    logic [NUM_SW-1:0]            level_q, level_d;
    logic [NUM_SW-1:0]            raise_q, raise_d;
    logic [NUM_SW-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    state_t                       state_q, state_d;
    logic [STAGE_W-1:0]           sel_q, sel_d;
    logic [BL_W-1:0]              blank_cnt_q, blank_cnt_d;
    logic [5:0]                   rgb_q, rgb_d;
    logic                         sound_q, sound_d;
    logic [NOTE_W-1:0]            note_q, note_d;
    logic [STAGE_W-1:0]           next_q, next_d;
    logic [1:0]                   ssel_q, ssel_d;
    logic                         blank_q, blank_d;
    logic [STAGE_W-1:0]           eff_stage;
    logic [5:0]                   rgb_sel;
    logic                         sound_sel;
    logic [NOTE_W-1:0]            note_sel_m;
    logic [STAGE_W-1:0]           next_sel;
    logic [1:0]                   ssel_sel;

    // Two-flop synchroniser followed by a per-switch stability counter.
    always_comb begin
        sync1_d  = sw_value;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Stage tracker: any change of the effective stage (re)starts the blanking window.
    always_comb begin
        eff_stage   = (32'(cur_stage) < NUM_STAGES) ? cur_stage : '0;
        state_d     = state_q;
        sel_d       = sel_q;
        blank_cnt_d = blank_cnt_q;
        if (eff_stage != sel_q) begin
            sel_d       = eff_stage;
            blank_cnt_d = BL_LOAD;
            state_d     = ST_BLANK;
        end else if (state_q == ST_BLANK) begin
            if (blank_cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                blank_cnt_d = blank_cnt_q - 1'b1;
            end
        end
    end

    // Output mux from the next selection; masking uses the next state so a stage
    // change and a completing rise on the same edge already see blanking.
    always_comb begin
        rgb_sel    = '0;
        sound_sel  = 1'b0;
        note_sel_m = '0;
        next_sel   = '0;
        ssel_sel   = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (sel_d == STAGE_W'(k)) begin
                rgb_sel    = st_rgb[6*k +: 6];
                sound_sel  = st_sound_en[k];
                note_sel_m = st_note_sel[NOTE_W*k +: NOTE_W];
                next_sel   = st_next_flag[STAGE_W*k +: STAGE_W];
                ssel_sel   = st_stage_sel[2*k +: 2];
            end
        end
        blank_d = (state_d == ST_BLANK);
        rgb_d   = blank_d ? '0 : rgb_sel;
        sound_d = blank_d ? 1'b0 : sound_sel;
        next_d  = blank_d ? '0 : next_sel;
        note_d  = note_sel_m;
        ssel_d  = ssel_sel;
        raise_d = level_d & ~level_q & {NUM_SW{~blank_d}};
    end

    // All state and registered outputs; reset overrides any pending stage change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            raise_q     <= '0;
            db_cnt_q    <= '0;
            state_q     <= ST_RUN;
            sel_q       <= '0;
            blank_cnt_q <= '0;
            rgb_q       <= '0;
            sound_q     <= 1'b0;
            note_q      <= '0;
            next_q      <= '0;
            ssel_q      <= '0;
            blank_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            raise_q     <= raise_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            blank_cnt_q <= blank_cnt_d;
            rgb_q       <= rgb_d;
            sound_q     <= sound_d;
            note_q      <= note_d;
            next_q      <= next_d;
            ssel_q      <= ssel_d;
            blank_q     <= blank_d;
        end
    end

    assign sw_level        = level_q;
    assign sw_raise        = raise_q;
    assign rgb_out         = rgb_q;
    assign sound_en        = sound_q;
    assign note_sel        = note_q;
    assign next_stage_flag = next_q;
    assign stage_select    = ssel_q;
    assign blanking        = blank_q;

endmodule

// File: tb/tb_stage_router.sv
// Bench for stage_router: directed scenarios with literal expectations, plus a
// behavioural model (sample-history debounce, time-since-last-change blanking)
// compared against every output on every clock.
module tb_stage_router;

  localparam int NS = 5;
  localparam int NSW = 4;
  localparam int NW = 4;
  localparam int SW_W = 3;
  localparam int DB = 16;
  localparam int BL = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSW-1:0]    sw_value;
  logic [SW_W-1:0]   cur_stage;
  logic [6*NS-1:0]   st_rgb;
  logic [NS-1:0]     st_sound_en;
  logic [NW*NS-1:0]  st_note_sel;
  logic [SW_W*NS-1:0] st_next_flag;
  logic [2*NS-1:0]   st_stage_sel;
  logic [NSW-1:0]    sw_level;
  logic [NSW-1:0]    sw_raise;
  logic [5:0]        rgb_out;
  logic              sound_en;
  logic [NW-1:0]     note_sel;
  logic [SW_W-1:0]   next_stage_flag;
  logic [1:0]        stage_select;
  logic              blanking;

  int checks = 0;
  int failures = 0;

  stage_router #(
    .NUM_STAGES(NS), .STAGE_W(SW_W), .NUM_SW(NSW), .NOTE_W(NW),
    .DEBOUNCE_CYC(DB), .BLANK_CYC(BL)
  ) dut (
    .clk(clk), .reset(reset), .sw_value(sw_value), .cur_stage(cur_stage),
    .st_rgb(st_rgb), .st_sound_en(st_sound_en), .st_note_sel(st_note_sel),
    .st_next_flag(st_next_flag), .st_stage_sel(st_stage_sel),
    .sw_level(sw_level), .sw_raise(sw_raise), .rgb_out(rgb_out),
    .sound_en(sound_en), .note_sel(note_sel), .next_stage_flag(next_stage_flag),
    .stage_select(stage_select), .blanking(blanking)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_stage(input int k, input logic [5:0] rgb, input logic snd,
                            input logic [3:0] note, input logic [2:0] nxt, input logic [1:0] ss);
    st_rgb[6*k +: 6]          = rgb;
    st_sound_en[k]            = snd;
    st_note_sel[NW*k +: NW]   = note;
    st_next_flag[SW_W*k +: SW_W] = nxt;
    st_stage_sel[2*k +: 2]    = ss;
  endtask

  task automatic load_tables();
    load_stage(0, 6'b010101, 1'b1, 4'h3, 3'd1, 2'd2);
    load_stage(1, 6'b111111, 1'b1, 4'h9, 3'd2, 2'd1);
    load_stage(2, 6'b101010, 1'b0, 4'hc, 3'd3, 2'd3);
    load_stage(3, 6'b110011, 1'b0, 4'h5, 3'd4, 2'd0);
    load_stage(4, 6'b001100, 1'b1, 4'he, 3'd7, 2'd3);
  endtask

  task automatic randomize_st();
    st_rgb       = 30'($urandom);
    st_sound_en  = 5'($urandom_range(0, 31));
    st_note_sel  = 20'($urandom);
    st_next_flag = 15'($urandom);
    st_stage_sel = 10'($urandom_range(0, 1023));
  endtask

  // counts consecutive negedges with blanking high, starting at the current one
  task automatic count_blank(output int n);
    n = 0;
    while (blanking === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  // behavioural model: debounce = last DB synchronised samples all differ from
  // the level; blanking = fewer than BL edges since the last stage change
  logic [NSW-1:0]  m_level;
  logic [NSW-1:0]  m_samp_prev;
  logic [NSW-1:0]  m_sync_hist[$];
  int              m_sel;
  int              m_since;
  logic [NSW-1:0]  e_level, e_raise;
  logic [5:0]      e_rgb;
  logic            e_sound, e_blank;
  logic [NW-1:0]   e_note;
  logic [SW_W-1:0] e_next;
  logic [1:0]      e_ssel;

  always @(posedge clk) begin
    logic [NSW-1:0] lvl_new;
    bit flip;
    int eff;
    if (reset) begin
      m_level = '0;
      m_sync_hist.delete();
      m_sync_hist.push_back('0);
      m_samp_prev = '0;
      m_sel = 0;
      m_since = BL;
      e_level = '0; e_raise = '0; e_rgb = '0; e_sound = 1'b0;
      e_note = '0; e_next = '0; e_ssel = '0; e_blank = 1'b0;
    end else begin
      lvl_new = m_level;
      if (m_sync_hist.size() >= DB) begin
        for (int i = 0; i < NSW; i++) begin
          flip = 1'b1;
          for (int j = m_sync_hist.size() - DB; j < m_sync_hist.size(); j++)
            if (m_sync_hist[j][i] == m_level[i]) flip = 1'b0;
          if (flip) lvl_new[i] = ~m_level[i];
        end
      end
      m_sync_hist.push_back(m_samp_prev);
      if (m_sync_hist.size() > DB) void'(m_sync_hist.pop_front());
      m_samp_prev = sw_value;
      eff = (int'(cur_stage) < NS) ? int'(cur_stage) : 0;
      if (eff != m_sel) begin
        m_sel = eff;
        m_since = 0;
      end else if (m_since < BL) begin
        m_since++;
      end
      e_blank = (m_since < BL);
      e_raise = lvl_new & ~m_level & {NSW{~e_blank}};
      m_level = lvl_new;
      e_level = lvl_new;
      e_rgb   = e_blank ? 6'd0 : st_rgb[6*m_sel +: 6];
      e_sound = e_blank ? 1'b0 : st_sound_en[m_sel];
      e_next  = e_blank ? 3'd0 : st_next_flag[SW_W*m_sel +: SW_W];
      e_note  = st_note_sel[NW*m_sel +: NW];
      e_ssel  = st_stage_sel[2*m_sel +: 2];
    end
    #1;
    check("m_sw_level", 32'(sw_level), 32'(e_level));
    check("m_sw_raise", 32'(sw_raise), 32'(e_raise));
    check("m_rgb_out", 32'(rgb_out), 32'(e_rgb));
    check("m_sound_en", 32'(sound_en), 32'(e_sound));
    check("m_note_sel", 32'(note_sel), 32'(e_note));
    check("m_next_flag", 32'(next_stage_flag), 32'(e_next));
    check("m_stage_select", 32'(stage_select), 32'(e_ssel));
    check("m_blanking", 32'(blanking), 32'(e_blank));
  end

  // scoreboard for rise pulses seen in directed windows
  logic [NSW-1:0] exp_q[$];

  initial begin
    int n;
    int first_lvl;
    int raises;
    bit saw;
    // reset defaults with arbitrary stage inputs
    reset = 1'b1;
    sw_value = '0;
    cur_stage = 3'd3;
    randomize_st();
    repeat (3) tick();
    check("reset_outputs_zero",
          32'({sw_level, sw_raise, rgb_out, sound_en, note_sel, next_stage_flag, stage_select, blanking}),
          32'd0);
    reset = 1'b0;
    cur_stage = 3'd0;
    load_tables();
    tick();
    check("post_reset_stage0",
          32'({rgb_out, sound_en, note_sel, next_stage_flag, stage_select, blanking}),
          32'({6'b010101, 1'b1, 4'h3, 3'd1, 2'd2, 1'b0}));

    // output mux latency: one cycle
    load_stage(0, 6'b000111, 1'b0, 4'h6, 3'd5, 2'd1);
    tick();
    check("mux_latency",
          32'({rgb_out, sound_en, note_sel, next_stage_flag, stage_select, blanking}),
          32'({6'b000111, 1'b0, 4'h6, 3'd5, 2'd1, 1'b0}));

    // stage switch 0 -> 1 with blanking
    cur_stage = 3'd1;
    tick();
    check("blank_start_forced",
          32'({rgb_out, sound_en, next_stage_flag, blanking}), 32'({6'd0, 1'b0, 3'd0, 1'b1}));
    check("blank_start_note_ssel", 32'({note_sel, stage_select}), 32'({4'h9, 2'd1}));
    count_blank(n);
    check("blank_len_0to1", 32'(n), 32'd8);
    check("stage1_after_blank",
          32'({rgb_out, sound_en, next_stage_flag}), 32'({6'b111111, 1'b1, 3'd2}));

    // short glitch on switch 2: no level change, no pulse
    saw = 1'b0;
    sw_value[2] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 9) sw_value[2] = 1'b0;
      if (sw_level[2] || sw_raise[2]) saw = 1'b1;
    end
    check("glitch_ignored", 32'(saw), 32'd0);

    // 40-cycle press on switch 2
    first_lvl = 0;
    raises = 0;
    sw_value[2] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (sw_level[2] && first_lvl == 0) first_lvl = k;
      if (sw_raise[2]) raises++;
      if (k == 40) sw_value[2] = 1'b0;
    end
    check("press_level_edge", 32'(first_lvl), 32'd18);
    check("press_raise_count", 32'(raises), 32'd1);
    check("press_released", 32'(sw_level[2]), 32'd0);

    // masked press: level rises at edge 18, stage change lands at edge 14
    raises = 0;
    sw_value[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (sw_raise[1]) begin
        raises++;
        exp_q.push_back(sw_raise);
      end
      if (k == 13) cur_stage = 3'd2;
    end
    check("masked_raise_count", 32'(raises), 32'd0);
    check("masked_queue_empty", 32'(exp_q.size()), 32'd0);
    check("masked_level_high", 32'(sw_level[1]), 32'd1);
    check("stage2_routed", 32'(rgb_out), 32'(6'b101010));
    sw_value[1] = 1'b0;
    repeat (25) tick();
    check("masked_released", 32'(sw_level[1]), 32'd0);

    // restart: 2 -> 1, then back to 2 three cycles into the window
    cur_stage = 3'd1;
    repeat (3) tick();
    cur_stage = 3'd2;
    tick();
    check("restart_note", 32'({note_sel, stage_select, blanking}), 32'({4'hc, 2'd3, 1'b1}));
    count_blank(n);
    check("restart_blank_len", 32'(n), 32'd8);
    check("restart_stage2", 32'({rgb_out, next_stage_flag}), 32'({6'b101010, 3'd3}));

    // out-of-range stage falls back to stage 0
    cur_stage = 3'd7;
    tick();
    count_blank(n);
    check("oor_blank_len", 32'(n), 32'd8);
    check("oor_stage0", 32'({rgb_out, note_sel}), 32'({6'b000111, 4'h6}));

    // stages 3 and 4 with changing inputs (model-checked each cycle)
    cur_stage = 3'd3;
    for (int k = 0; k < 20; k++) begin
      tick();
      randomize_st();
    end
    cur_stage = 3'd4;
    for (int k = 0; k < 20; k++) begin
      tick();
      randomize_st();
    end
    load_tables();
    load_stage(0, 6'b000111, 1'b0, 4'h6, 3'd5, 2'd1);
    tick();
    check("stage4_table", 32'({rgb_out, note_sel, next_stage_flag}), 32'({6'b001100, 4'he, 3'd7}));

    // reset two cycles into BLANK, with a stage change on the same edge as reset
    cur_stage = 3'd1;
    tick();
    tick();
    check("pre_reset_blanking", 32'(blanking), 32'd1);
    reset = 1'b1;
    cur_stage = 3'd3;
    tick();
    check("reset_wins",
          32'({sw_raise, rgb_out, sound_en, note_sel, next_stage_flag, stage_select, blanking}),
          32'd0);
    cur_stage = 3'd0;
    tick();
    reset = 1'b0;
    tick();
    check("reset_midblank_stage0",
          32'({rgb_out, sound_en, note_sel, next_stage_flag, stage_select, blanking}),
          32'({6'b000111, 1'b0, 4'h6, 3'd5, 2'd1, 1'b0}));
    repeat (3) tick();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
